rotate_engine: RTL and testbench
================================

ROTATE_ENGINE -- requirements
Module: rotate_engine

Interface
REQ-001 SHALL have parameter LOG_N, default 8, meaning log2 of the square frame side N (N = 2**LOG_N; 256x256 by default).
REQ-002 SHALL have parameter PIX_W, default 24, meaning pixel width in bits (8-bit RGB by default).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning the reset, which is synchronous and active-high.
REQ-005 SHALL have port rot  input  2  meaning the rotation: 0 = none, 1 = 90 cw, 2 = 180, 3 = 270 cw.
REQ-006 SHALL have port in_valid  input  1  meaning an input pixel is offered.
REQ-007 SHALL have port in_data  input  PIX_W  meaning the input pixel, raster order.
REQ-008 SHALL have port in_ready  output  1  meaning the engine accepts in_data this cycle.
REQ-009 SHALL have port out_valid  output  1  meaning out_data holds a valid rotated pixel.
REQ-010 SHALL have port out_data  output  PIX_W  meaning the output pixel, raster order of the rotated frame.
REQ-011 SHALL have port out_ready  input  1  meaning the sink accepts out_data this cycle.
REQ-012 SHALL have port out_sol  output  1  meaning out_data is column 0 of an output row.
REQ-013 SHALL have port out_eof  output  1  meaning out_data is the last pixel of the frame.
REQ-014 SHALL have port busy  output  1  meaning the engine is not in IDLE.

Function
REQ-015 SHALL hold an internal single-port frame buffer of N*N x PIX_W words with 1-cycle read latency.
REQ-016 SHALL implement states IDLE, FILL and DRAIN: IDLE->FILL on the first input handshake, FILL->DRAIN on the N*N-th input handshake, DRAIN->IDLE on the N*N-th output handshake.
REQ-017 SHALL count a handshake only when valid and ready are both high at a rising edge.
REQ-018 SHALL assert in_ready only in IDLE and FILL, so filling and draining never overlap.
REQ-019 SHALL write each input pixel at source address row*N+col, with col wrapping N-1->0 and incrementing row.
REQ-020 SHALL sample rot at the first input handshake of a frame and ignore later changes until the next frame.
REQ-021 SHALL map output position (r,c) to a source position as follows: rot 0 reads (r,c); rot 1 reads (N-1-c, r); rot 2 reads (N-1-r, N-1-c); rot 3 reads (c, N-1-r).
REQ-022 SHALL assert out_valid for the first pixel no earlier than 2 cycles after the last input handshake.
REQ-023 SHALL keep out_data, out_sol and out_eof stable while out_valid=1 and out_ready=0.
REQ-024 SHALL sustain one pixel per cycle in DRAIN while out_ready=1, using a 2-entry output buffer.
REQ-025 SHALL assert out_sol when c=0 and out_eof when r=c=N-1.
REQ-026 SHALL return to IDLE after the final output handshake and raise in_ready in the next cycle.
REQ-027 SHALL drop input offered while in_ready=0 without storing it.

Reset
REQ-028 SHALL, while rst=1, force the state to IDLE and clear all counters, the latched rot and the output buffer.
REQ-029 SHALL drive in_ready=0, out_valid=0, out_sol=0, out_eof=0, busy=0 and out_data=0 during reset.
REQ-030 SHALL discard any partial frame on reset mid-FILL or mid-DRAIN, leave the buffer contents undefined, and raise in_ready in the first cycle after rst falls.

Configuration
REQ-031 SHALL, when macro ROTATE_MIRROR_EN is defined, add input port mirror (1 bit), sampled together with rot, which maps the output column c to N-1-c after rotation.
REQ-032 SHALL, when ROTATE_MIRROR_EN is not defined, omit the mirror port and behave as if mirror=0.

Verification
REQ-033 SHALL cover: LOG_N=2, rot=0, pixels 0..15 -> outputs 0..15; out_sol on 0,4,8,12; out_eof on 15.
REQ-034 SHALL cover: LOG_N=2, rot=1, pixels 0..15 -> row 0 outputs 12,8,4,0; last output 3.
REQ-035 SHALL cover: LOG_N=2, rot=2 -> outputs 15..0; rot=3 -> row 0 outputs 3,7,11,15.
REQ-036 SHALL cover: rot=1 with out_ready toggled randomly and rot changed mid-frame -> same sequence as REQ-034, no drops or duplicates, data held stable while stalled.
REQ-037 SHALL cover: rst asserted after 7 input pixels -> busy=0 and out_valid=0 next cycle; the next full frame with rot=0 outputs 0..15.
REQ-038 SHALL cover: with ROTATE_MIRROR_EN defined, LOG_N=2, rot=0, mirror=1 -> row 0 outputs 3,2,1,0.

Source files
------------

// File: rtl/rotate_engine.sv
// -----------------------------------------------------------------------------
// rotate_engine
//
// Purpose:
//   Buffers one square N x N frame (N = 2**LOG_N) arriving in raster order,
//   then replays it in raster order of the rotated frame (0/90/180/270 cw).
//   Filling and draining never overlap: the frame buffer is single-ported and
//   is written during FILL and read during DRAIN.
//
// Optional feature (macro ROTATE_MIRROR_EN):
//   When defined, an extra input port 'mirror' is present.  It is sampled
//   together with 'rot' at the first input handshake of a frame.  When it is
//   set, output column c is taken as N-1-c after rotation.  When the macro is
//   undefined the port does not exist and the engine behaves as mirror=0.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   mirror     in   horizontal mirror (only with ROTATE_MIRROR_EN)
//   rot        in   [1:0] rotation 0=none 1=90cw 2=180 3=270cw
//   in_valid   in   input pixel offered
//   in_data    in   [PIX_W-1:0] input pixel, raster order
//   in_ready   out  engine accepts in_data this cycle (IDLE/FILL only)
//   out_valid  out  out_data holds a valid rotated pixel
//   out_data   out  [PIX_W-1:0] output pixel, raster order of rotated frame
//   out_ready  in   sink accepts out_data this cycle
//   out_sol    out  out_data is column 0 of an output row
//   out_eof    out  out_data is the last pixel of the frame
//   busy       out  engine is not in IDLE
// -----------------------------------------------------------------------------
module rotate_engine #(
  parameter int LOG_N = 8,
  parameter int PIX_W = 24
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ROTATE_MIRROR_EN
  input  logic             mirror,
`endif
  input  logic [1:0]       rot,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_data,
  input  logic             out_ready,
  output logic             out_sol,
  output logic             out_eof,
  output logic             busy
);

  localparam int AW    = 2 * LOG_N;
  localparam int DEPTH = 1 << AW;

  localparam logic [LOG_N-1:0] CMAX = '1;  // N-1
  localparam logic [AW-1:0]    LAST = '1;  // N*N-1

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Source address of output position (r,c).  N-1-x is just ~x in LOG_N bits.
  // Mirroring is applied to the output column before the rotation lookup.
  function automatic logic [AW-1:0] src_addr(
    input logic [1:0]       rv,
    input logic             mir,
    input logic [LOG_N-1:0] r,
    input logic [LOG_N-1:0] c
  );
    logic [LOG_N-1:0] cm;
    logic [LOG_N-1:0] sr;
    logic [LOG_N-1:0] sc;
    cm = mir ? ~c : c;
    case (rv)
      2'd0:    begin sr = r;   sc = cm;  end
      2'd1:    begin sr = ~cm; sc = r;   end
      2'd2:    begin sr = ~r;  sc = ~cm; end
      default: begin sr = cm;  sc = ~r;  end
    endcase
    return {sr, sc};
  endfunction

  // Control state
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [AW-1:0]    r_in_cnt;
  logic [1:0]       r_rot;
  logic             r_mir;
  logic [LOG_N-1:0] r_rd_row;
  logic [LOG_N-1:0] r_rd_col;
  logic             r_iss_done;
  logic [AW-1:0]    r_out_cnt;

  // Frame buffer and read stage
  logic [PIX_W-1:0] r_mem [DEPTH];
  logic [PIX_W-1:0] r_rd_data;
  logic             r_rd_vld;
  logic             r_rd_sol;
  logic             r_rd_eof;

  // Two-entry output buffer
  logic [PIX_W-1:0] r_q_data [2];
  logic [1:0]       r_q_sol;
  logic [1:0]       r_q_eof;
  logic             r_q_wp;
  logic             r_q_rp;
  logic [1:0]       r_q_cnt;

  logic             w_mir_in;
  logic             w_in_ready;
  logic             w_in_hs;
  logic             w_out_valid;
  logic             w_out_hs;
  logic [1:0]       w_occ;
  logic             w_issue;
  logic [AW-1:0]    w_rd_addr;

`ifdef ROTATE_MIRROR_EN
  assign w_mir_in = mirror;
`else
  assign w_mir_in = 1'b0;
`endif

  assign w_in_ready  = !rst && (r_state != S_DRAIN);
  assign w_in_hs     = in_valid && w_in_ready;
  assign w_out_valid = !rst && (r_q_cnt != 2'd0);
  assign w_out_hs    = w_out_valid && out_ready;

  // Slots already committed: buffered entries plus the read in flight.
  // A new read may be issued if a slot is free now or one frees this cycle,
  // which keeps one pixel per cycle flowing with a 1-cycle RAM latency.
  assign w_occ   = r_q_cnt + {1'b0, r_rd_vld};
  assign w_issue = (r_state == S_DRAIN) && !r_iss_done &&
                   ((w_occ < 2'd2) || w_out_hs);

  assign w_rd_addr = src_addr(r_rot, r_mir, r_rd_row, r_rd_col);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_in_hs) begin
          w_state_nxt = (r_in_cnt == LAST) ? S_DRAIN : S_FILL;
        end
      end
      S_FILL: begin
        if (w_in_hs && (r_in_cnt == LAST)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_out_hs && (r_out_cnt == LAST)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- stage 0: input write / read issue (control) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_in_cnt   <= '0;
      r_rot      <= 2'd0;
      r_mir      <= 1'b0;
      r_rd_row   <= '0;
      r_rd_col   <= '0;
      r_iss_done <= 1'b0;
      r_out_cnt  <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_sol   <= 1'b0;
      r_rd_eof   <= 1'b0;
      r_q_wp     <= 1'b0;
      r_q_rp     <= 1'b0;
      r_q_cnt    <= 2'd0;
    end else begin
      r_state <= w_state_nxt;

      if (w_in_hs) begin
        // counter wraps back to 0 after the last pixel of the frame
        r_in_cnt <= r_in_cnt + 1'b1;
        if (r_state == S_IDLE) begin
          r_rot <= rot;
          r_mir <= w_mir_in;
        end
      end

      if (w_issue) begin
        r_rd_col <= r_rd_col + 1'b1;
        if (r_rd_col == CMAX) begin
          r_rd_row <= r_rd_row + 1'b1;
          if (r_rd_row == CMAX) begin
            r_iss_done <= 1'b1;
          end
        end
      end

      r_rd_vld <= w_issue;
      r_rd_sol <= (r_rd_col == '0);
      r_rd_eof <= (r_rd_row == CMAX) && (r_rd_col == CMAX);

      // ---- stage 1: read data into output buffer (control) ----
      if (r_rd_vld) begin
        r_q_wp <= ~r_q_wp;
      end
      if (w_out_hs) begin
        r_q_rp    <= ~r_q_rp;
        r_out_cnt <= r_out_cnt + 1'b1;
        if (r_out_cnt == LAST) begin
          r_iss_done <= 1'b0;
        end
      end
      r_q_cnt <= r_q_cnt + {1'b0, r_rd_vld} - {1'b0, w_out_hs};
    end
  end

  // ---- stage 0: frame buffer port (data, no reset) ----
  always_ff @(posedge clk) begin
    if (w_in_hs) begin
      r_mem[r_in_cnt] <= in_data;
    end else if (w_issue) begin
      r_rd_data <= r_mem[w_rd_addr];
    end
  end

  // ---- stage 1: output buffer storage (data, no reset) ----
  always_ff @(posedge clk) begin
    if (r_rd_vld) begin
      r_q_data[r_q_wp] <= r_rd_data;
      r_q_sol[r_q_wp]  <= r_rd_sol;
      r_q_eof[r_q_wp]  <= r_rd_eof;
    end
  end

  // ---- stage 2: output head ----
  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_out_valid ? r_q_data[r_q_rp] : '0;
  assign out_sol   = w_out_valid && r_q_sol[r_q_rp];
  assign out_eof   = w_out_valid && r_q_eof[r_q_rp];
  assign busy      = !rst && (r_state != S_IDLE);

endmodule

// File: tb/tb_rotate_engine.sv
// -----------------------------------------------------------------------------
// tb_rotate_engine
//
// Self-checking bench for rotate_engine with LOG_N=2 (4x4 frames), PIX_W=8.
// Input pixels are 0..15 in raster order; expected output orders are written
// out by hand per rotation.  The mirror case runs only with ROTATE_MIRROR_EN.
// -----------------------------------------------------------------------------
module tb_rotate_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       mirror;
  logic [1:0] rot;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       out_sol;
  logic       out_eof;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] q_d [$];
  logic       q_s [$];
  logic       q_e [$];

  logic [7:0] EXP_R0 [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
  logic [7:0] EXP_R1 [16] = '{12, 8, 4, 0, 13, 9, 5, 1, 14, 10, 6, 2, 15, 11, 7, 3};
  logic [7:0] EXP_R2 [16] = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
  logic [7:0] EXP_R3 [16] = '{3, 7, 11, 15, 2, 6, 10, 14, 1, 5, 9, 13, 0, 4, 8, 12};
  logic [7:0] EXP_M0 [16] = '{3, 2, 1, 0, 7, 6, 5, 4, 11, 10, 9, 8, 15, 14, 13, 12};

  always #5 clk = ~clk;

  rotate_engine #(.LOG_N(2), .PIX_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ROTATE_MIRROR_EN
    .mirror    (mirror),
`endif
    .rot       (rot),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_sol   (out_sol),
    .out_eof   (out_eof),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor: records handshakes and checks that a stalled head holds.
  initial begin
    logic       stalled;
    logic [7:0] hold_d;
    logic       hold_s;
    logic       hold_e;
    stalled = 1'b0;
    hold_d  = '0;
    hold_s  = 1'b0;
    hold_e  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (stalled) begin
          chk("hold_data", out_data, hold_d);
          chk("hold_sol", out_sol, hold_s);
          chk("hold_eof", out_eof, hold_e);
        end
        if (out_ready) begin
          q_d.push_back(out_data);
          q_s.push_back(out_sol);
          q_e.push_back(out_eof);
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hold_d  = out_data;
          hold_s  = out_sol;
          hold_e  = out_eof;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  // Offers npix pixels 0..npix-1; optionally changes rot after the first one.
  task automatic send_frame(input logic [1:0] rv, input bit chg, input int npix);
    bit hs;
    int cyc;
    q_d.delete();
    q_s.delete();
    q_e.delete();
    rot = rv;
    for (int i = 0; i < npix; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 8'(i);
      if (chg && i > 0) rot = rv + 2'd1;
      hs  = 1'b0;
      cyc = 0;
      do begin
        @(negedge clk);
        hs = in_ready;
        cyc++;
        if (!hs) @(posedge clk);
      end while (!hs && cyc < 50);
      if (!hs) begin
        chk($sformatf("in_timeout_%0d", i), 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (npix == 16) begin
      @(negedge clk);
      chk("early_out_valid", out_valid, 0);
      chk("in_ready_drain", in_ready, 0);
      chk("busy_drain", busy, 1);
    end
  endtask

  task automatic drain_frame(input string nm, input bit rnd, input bit junk,
                             input logic [7:0] exp [16]);
    int cyc;
    cyc = 0;
    while (q_d.size() < 16 && cyc < 400) begin
      @(posedge clk);
      #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = junk && (cyc < 4);
      in_data   = 8'hAA;
      cyc++;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    chk({nm, "_count"}, q_d.size(), 16);
    for (int k = 0; k < q_d.size() && k < 16; k++) begin
      chk($sformatf("%s_d%0d", nm, k), q_d[k], exp[k]);
      chk($sformatf("%s_sol%0d", nm, k), q_s[k], (k % 4) == 0);
      chk($sformatf("%s_eof%0d", nm, k), q_e[k], k == 15);
    end
    @(negedge clk);
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_idle_in_ready"}, in_ready, 1);
  endtask

  initial begin
    rst       = 1'b1;
    mirror    = 1'b0;
    rot       = 2'd0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sol", out_sol, 0);
    chk("rst_eof", out_eof, 0);
    chk("rst_data", out_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);

    send_frame(2'd0, 1'b0, 16);
    drain_frame("rot0", 1'b0, 1'b0, EXP_R0);
    send_frame(2'd1, 1'b0, 16);
    drain_frame("rot1", 1'b0, 1'b0, EXP_R1);
    send_frame(2'd2, 1'b0, 16);
    drain_frame("rot2", 1'b0, 1'b0, EXP_R2);
    send_frame(2'd3, 1'b0, 16);
    drain_frame("rot3", 1'b0, 1'b0, EXP_R3);

    // stalls, rot changed mid-frame, input offered while draining
    send_frame(2'd1, 1'b1, 16);
    drain_frame("rot1_stall", 1'b1, 1'b1, EXP_R1);

    // reset in the middle of a fill
    send_frame(2'd2, 1'b0, 7);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_busy", busy, 0);
    chk("after_rst_out_valid", out_valid, 0);
    chk("after_rst_in_ready", in_ready, 1);
    send_frame(2'd0, 1'b0, 16);
    drain_frame("rot0_after_rst", 1'b0, 1'b0, EXP_R0);

`ifdef ROTATE_MIRROR_EN
    mirror = 1'b1;
    send_frame(2'd0, 1'b0, 16);
    mirror = 1'b0;
    drain_frame("mirror", 1'b0, 1'b0, EXP_M0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
